// File: rtl/level_indexed_trail.sv
// ============================================================================
// Module   : level_indexed_trail
// Brief    : Assignment trail with per-variable lookup table and level-indexed
//            backtrack that streams removed entries out, newest first.
//            Optional macro TRAIL_DUP_CHECK_EN refuses pushes of assigned vars.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_indexed_trail #(
    parameter int MAX_VARS  = 256,
    parameter int VAR_W     = 32,
    parameter int LEVEL_W   = 16,
    parameter int REASON_W  = 16,
    localparam int IDX_W    = $clog2(MAX_VARS) + 1
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                push_valid,
    output logic                push_ready,
    input  logic [VAR_W-1:0]    push_var,
    input  logic                push_value,
    input  logic                push_is_decision,
    input  logic [REASON_W-1:0] push_reason,

    output logic [IDX_W-1:0]    height,
    output logic [LEVEL_W-1:0]  current_level,

    input  logic                bt_req,
    input  logic [LEVEL_W-1:0]  bt_level,
    output logic                bt_done,
    output logic                unwind_valid,
    input  logic                unwind_ready,
    output logic [VAR_W-1:0]    unwind_var,
    output logic                unwind_value,
    output logic                unwind_is_decision,

    input  logic [VAR_W-1:0]    query_var,
    output logic                query_valid,
    output logic                query_value,
    output logic [LEVEL_W-1:0]  query_level,
    output logic [REASON_W-1:0] query_reason,

    input  logic [IDX_W-1:0]    read_idx,
    output logic [VAR_W-1:0]    read_var,
    output logic                read_value,
    output logic [LEVEL_W-1:0]  read_level,
    output logic                read_is_decision,
    output logic [REASON_W-1:0] read_reason,

    input  logic                clear_all,
    output logic                err_dup
);

    localparam int                  c_addr_w    = IDX_W - 1;
    localparam int                  c_ls_depth  = 1 << IDX_W;
    localparam logic [IDX_W-1:0]    c_max_h     = IDX_W'(MAX_VARS);
    localparam logic [IDX_W-1:0]    c_one_h     = IDX_W'(1);
    localparam logic [LEVEL_W-1:0]  c_one_l     = LEVEL_W'(1);
    localparam logic [REASON_W-1:0] c_no_reason = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNWIND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]    r_height;
    logic [LEVEL_W-1:0]  r_level;
    logic [IDX_W-1:0]    r_cut;
    logic [LEVEL_W-1:0]  r_bt_level;
    logic [MAX_VARS-1:0] r_valid;

    logic [VAR_W-1:0]    r_tr_var    [0:MAX_VARS-1];
    logic                r_tr_value  [0:MAX_VARS-1];
    logic [LEVEL_W-1:0]  r_tr_level  [0:MAX_VARS-1];
    logic                r_tr_dec    [0:MAX_VARS-1];
    logic [REASON_W-1:0] r_tr_reason [0:MAX_VARS-1];

    logic                r_vt_value  [0:MAX_VARS-1];
    logic [LEVEL_W-1:0]  r_vt_level  [0:MAX_VARS-1];
    logic [REASON_W-1:0] r_vt_reason [0:MAX_VARS-1];

    // Height at which each level's decision was pushed; only levels
    // 1..current_level are ever consulted.
    logic [IDX_W-1:0]    r_level_start [0:c_ls_depth-1];

    logic [c_addr_w-1:0] w_push_idx;
    logic [c_addr_w-1:0] w_q_idx;
    logic [c_addr_w-1:0] w_h_idx;
    logic [c_addr_w-1:0] w_rd_idx;
    logic [IDX_W-1:0]    w_top;
    logic [c_addr_w-1:0] w_top_idx;
    logic [VAR_W-1:0]    w_top_var;
    logic [LEVEL_W-1:0]  w_push_level;
    logic [IDX_W-1:0]    w_ls_wr_idx;
    logic [IDX_W-1:0]    w_ls_rd_idx;
    logic                w_push_fire;
    logic                w_push_acc;
    logic                w_dup;
    logic                w_bt_start;
    logic                w_bt_cut;
    logic                w_pop;
    logic                w_rd_ok;

    assign w_push_idx   = push_var[c_addr_w-1:0];
    assign w_q_idx      = query_var[c_addr_w-1:0];
    assign w_h_idx      = r_height[c_addr_w-1:0];
    assign w_rd_idx     = read_idx[c_addr_w-1:0];
    assign w_top        = r_height - c_one_h;
    assign w_top_idx    = w_top[c_addr_w-1:0];
    assign w_top_var    = r_tr_var[w_top_idx];
    assign w_push_level = push_is_decision ? (r_level + c_one_l) : r_level;
    assign w_ls_wr_idx  = IDX_W'(w_push_level);
    assign w_ls_rd_idx  = IDX_W'(bt_level + c_one_l);

    assign push_ready   = (r_state == IDLE) && (r_height < c_max_h) && !bt_req && !clear_all;
    assign w_push_fire  = push_valid && push_ready;
    assign w_push_acc   = w_push_fire && !w_dup;
    assign w_bt_start   = (r_state == IDLE) && bt_req && !clear_all;
    assign w_bt_cut     = bt_level < r_level;
    assign w_pop        = unwind_valid && unwind_ready;

`ifdef TRAIL_DUP_CHECK_EN
    logic r_err_dup;

    assign w_dup   = r_valid[w_push_idx];
    assign err_dup = r_err_dup;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_dup <= 1'b0;
        end else if (clear_all) begin
            r_err_dup <= 1'b0;
        end else if (w_push_fire && w_dup) begin
            r_err_dup <= 1'b1;
        end
    end
`else
    assign w_dup   = 1'b0;
    assign err_dup = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        unwind_valid = 1'b0;
        bt_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bt_start) begin
                    w_state_nxt = w_bt_cut ? UNWIND : DONE;
                end
            end
            UNWIND: begin
                unwind_valid = (r_height != r_cut);
                if (r_height == r_cut) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bt_done     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear_all) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_height   <= '0;
            r_level    <= '0;
            r_cut      <= '0;
            r_bt_level <= '0;
            r_valid    <= '0;
        end else if (clear_all) begin
            r_height <= '0;
            r_level  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push_acc) begin
                r_height            <= r_height + c_one_h;
                r_valid[w_push_idx] <= 1'b1;
                r_level             <= w_push_level;
            end
            // A no-op backtrack latches the current level so DONE leaves it unchanged.
            if (w_bt_start) begin
                r_cut      <= w_bt_cut ? r_level_start[w_ls_rd_idx] : r_height;
                r_bt_level <= w_bt_cut ? bt_level : r_level;
            end
            if (w_pop) begin
                r_height                         <= w_top;
                r_valid[w_top_var[c_addr_w-1:0]] <= 1'b0;
            end
            if (r_state == DONE) begin
                r_level <= r_bt_level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_tr_var[w_h_idx]       <= push_var;
            r_tr_value[w_h_idx]     <= push_value;
            r_tr_level[w_h_idx]     <= w_push_level;
            r_tr_dec[w_h_idx]       <= push_is_decision;
            r_tr_reason[w_h_idx]    <= push_reason;
            r_vt_value[w_push_idx]  <= push_value;
            r_vt_level[w_push_idx]  <= w_push_level;
            r_vt_reason[w_push_idx] <= push_reason;
            if (push_is_decision) begin
                r_level_start[w_ls_wr_idx] <= r_height;
            end
        end
    end

    assign height        = r_height;
    assign current_level = r_level;

    assign query_valid  = r_valid[w_q_idx];
    assign query_value  = query_valid & r_vt_value[w_q_idx];
    assign query_level  = query_valid ? r_vt_level[w_q_idx] : '0;
    assign query_reason = query_valid ? r_vt_reason[w_q_idx] : c_no_reason;

    assign w_rd_ok          = read_idx < r_height;
    assign read_var         = w_rd_ok ? r_tr_var[w_rd_idx] : '0;
    assign read_value       = w_rd_ok & r_tr_value[w_rd_idx];
    assign read_level       = w_rd_ok ? r_tr_level[w_rd_idx] : '0;
    assign read_is_decision = w_rd_ok & r_tr_dec[w_rd_idx];
    assign read_reason      = w_rd_ok ? r_tr_reason[w_rd_idx] : c_no_reason;

    assign unwind_var         = unwind_valid ? w_top_var : '0;
    assign unwind_value       = unwind_valid & r_tr_value[w_top_idx];
    assign unwind_is_decision = unwind_valid & r_tr_dec[w_top_idx];

    // Query IDs alias onto the table through their low bits only.
    generate
        if (VAR_W > c_addr_w) begin : g_qhi
            logic w_unused_qhi;
            assign w_unused_qhi = ^query_var[VAR_W-1:c_addr_w];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_level_indexed_trail.sv
// ============================================================================
// Module   : tb_level_indexed_trail
// Brief    : Directed and random checks of level_indexed_trail against a
//            queue-based model of the trail and variable table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_level_indexed_trail;

    localparam int MP = 8;

`ifdef TRAIL_DUP_CHECK_EN
    localparam bit DUPCHK = 1'b1;
`else
    localparam bit DUPCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       push_valid = 0, push_value = 0, push_is_decision = 0;
    logic [7:0] push_var = 0, push_reason = 0;
    logic       push_ready;
    logic [3:0] height;
    logic [7:0] current_level;
    logic       bt_req = 0, unwind_ready = 0, clear_all = 0;
    logic [7:0] bt_level = 0;
    logic       bt_done, unwind_valid, unwind_value, unwind_is_decision;
    logic [7:0] unwind_var;
    logic [7:0] query_var = 0;
    logic       query_valid, query_value;
    logic [7:0] query_level, query_reason;
    logic [3:0] read_idx = 0;
    logic [7:0] read_var, read_level, read_reason;
    logic       read_value, read_is_decision;
    logic       err_dup;

    always #5 clk = ~clk;

    level_indexed_trail #(.MAX_VARS(MP), .VAR_W(8), .LEVEL_W(8), .REASON_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_var(push_var),
        .push_value(push_value), .push_is_decision(push_is_decision), .push_reason(push_reason),
        .height(height), .current_level(current_level),
        .bt_req(bt_req), .bt_level(bt_level), .bt_done(bt_done),
        .unwind_valid(unwind_valid), .unwind_ready(unwind_ready), .unwind_var(unwind_var),
        .unwind_value(unwind_value), .unwind_is_decision(unwind_is_decision),
        .query_var(query_var), .query_valid(query_valid), .query_value(query_value),
        .query_level(query_level), .query_reason(query_reason),
        .read_idx(read_idx), .read_var(read_var), .read_value(read_value),
        .read_level(read_level), .read_is_decision(read_is_decision), .read_reason(read_reason),
        .clear_all(clear_all), .err_dup(err_dup)
    );

    typedef struct {
        logic [7:0] v;
        logic       val;
        logic [7:0] lvl;
        logic       dec;
        logic [7:0] rsn;
    } ent_t;

    ent_t m_q[$];
    int   m_lvl;
    bit   m_err;
    bit   m_valid [MP];
    bit   m_val   [MP];
    int   m_tlvl  [MP];
    int   m_rsn   [MP];
    int   n_pass  = 0;
    int   n_total = 0;
    int   lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        m_q.delete();
        m_lvl = 0;
        m_err = 0;
        for (int i = 0; i < MP; i++) m_valid[i] = 0;
    endtask

    task automatic do_clear();
        clear_all = 1;
        cyc();
        clear_all = 0;
        m_clear();
    endtask

    task automatic check_state(input string tag);
        int v;
        #2;
        chk({tag, "_height"}, height, m_q.size());
        chk({tag, "_level"}, current_level, m_lvl);
        chk({tag, "_err_dup"}, err_dup, m_err);
        for (int i = 0; i <= MP; i++) begin
            v = i % MP;
            query_var = 8'(($urandom_range(0, 31) & 32'hf8) | v);
            read_idx  = 4'(i);
            @(negedge clk);
            chk({tag, "_q_valid"}, query_valid, m_valid[v]);
            chk({tag, "_q_value"}, query_value, m_valid[v] ? m_val[v] : 0);
            chk({tag, "_q_level"}, query_level, m_valid[v] ? m_tlvl[v] : 0);
            chk({tag, "_q_reason"}, query_reason, m_valid[v] ? m_rsn[v] : 8'hff);
            if (i < m_q.size()) begin
                chk({tag, "_rd_var"}, read_var, m_q[i].v);
                chk({tag, "_rd_value"}, read_value, m_q[i].val);
                chk({tag, "_rd_level"}, read_level, m_q[i].lvl);
                chk({tag, "_rd_dec"}, read_is_decision, m_q[i].dec);
                chk({tag, "_rd_reason"}, read_reason, m_q[i].rsn);
            end else begin
                chk({tag, "_rd_var_oob"}, read_var, 0);
                chk({tag, "_rd_reason_oob"}, read_reason, 8'hff);
            end
        end
        cyc();
    endtask

    task automatic push(input logic [7:0] v, input bit val, input bit dec, input logic [7:0] r);
        bit   exp_rdy;
        int   idx;
        ent_t e;
        push_var = v; push_value = val; push_is_decision = dec; push_reason = r;
        push_valid = 1;
        #2;
        exp_rdy = (m_q.size() < MP);
        chk("push_ready", push_ready, exp_rdy);
        cyc();
        push_valid = 0;
        idx = v % MP;
        if (exp_rdy) begin
            if (DUPCHK && m_valid[idx]) begin
                m_err = 1;
            end else begin
                e.v = v; e.val = val; e.dec = dec; e.rsn = r;
                e.lvl = 8'(dec ? m_lvl + 1 : m_lvl);
                m_q.push_back(e);
                if (dec) m_lvl++;
                m_valid[idx] = 1; m_val[idx] = val; m_tlvl[idx] = e.lvl; m_rsn[idx] = r;
            end
        end
    endtask

    // Removes every entry above tgt, newest first; latency is measured from the request cycle.
    task automatic backtrack(input int tgt, input int stall_first, input bit rnd, output int lt);
        int n, stalls, k;
        bit rdy, uv, avail;
        n = 0;
        if (tgt < m_lvl) foreach (m_q[i]) if (m_q[i].lvl > tgt) n++;
        bt_req = 1; bt_level = 8'(tgt);
        #2;
        chk("bt_blocks_push", push_ready, 0);
        cyc();
        bt_req = 0;
        stalls = 0; k = 0; lt = -1;
        for (int c = 1; c <= 300; c++) begin
            rdy = rnd ? ($urandom_range(0, 2) != 0) : (k >= stall_first);
            unwind_ready = rdy;
            #2;
            if (bt_done) begin
                lt = c;
                break;
            end
            uv = unwind_valid;
            avail = (tgt < m_lvl) && (m_q.size() > 0) && (m_q[$].lvl > tgt);
            if (uv) begin
                k++;
                chk("unwind_expected", uv, avail);
                if (avail) begin
                    chk("unwind_var", unwind_var, m_q[$].v);
                    chk("unwind_value", unwind_value, m_q[$].val);
                    chk("unwind_dec", unwind_is_decision, m_q[$].dec);
                end
                if (!rdy) stalls++;
            end
            cyc();
            if (uv && rdy && avail) begin
                m_valid[m_q[$].v % MP] = 0;
                void'(m_q.pop_back());
            end
        end
        unwind_ready = 0;
        if (lt < 0) begin
            chk("bt_timeout", bt_done, 1);
        end else begin
            chk("bt_latency", lt, (tgt < m_lvl) ? 2 + n + stalls : 1);
            cyc();
            if (tgt < m_lvl) m_lvl = tgt;
            #2;
            chk("bt_single_pulse", bt_done, 0);
            chk("bt_level_after", current_level, m_lvl);
            chk("bt_height_after", height, m_q.size());
            cyc();
        end
    endtask

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_height", height, 0);
        chk("rst_level", current_level, 0);
        chk("rst_bt_done", bt_done, 0);
        chk("rst_unwind_valid", unwind_valid, 0);
        chk("rst_err_dup", err_dup, 0);
        @(posedge clk); #1;
        reset_n = 1;
        cyc();
        check_state("reset");

        push(8'd5, 1, 1, 8'hff);
        push(8'd7, 0, 0, 8'h11);
        push(8'd9, 1, 0, 8'h22);
        query_var = 8'd7;
        #2;
        chk("t1_height", height, 3);
        chk("t1_level", current_level, 1);
        chk("t1_q7_valid", query_valid, 1);
        chk("t1_q7_level", query_level, 1);
        cyc();
        check_state("t1");

        do_clear();
        push(8'd1, 1, 1, 8'h01); push(8'd2, 0, 0, 8'h02);
        push(8'd3, 1, 1, 8'h03); push(8'd4, 0, 0, 8'h04);
        push(8'd6, 0, 1, 8'h06); push(8'd7, 1, 0, 8'h07);
        backtrack(1, 0, 0, lat);
        chk("t2_latency", lat, 6);
        #2;
        chk("t2_height", height, 2);
        chk("t2_level", current_level, 1);
        cyc();
        check_state("t2");

        push(8'd3, 0, 1, 8'h13); push(8'd4, 1, 0, 8'h14);
        push(8'd6, 1, 1, 8'h16); push(8'd0, 0, 0, 8'h10);
        backtrack(1, 3, 0, lat);
        chk("t3_stall_latency", lat, 9);

        backtrack(3, 0, 0, lat);
        chk("t4_noop_latency", lat, 1);
        check_state("t4");

        push(8'd3, 0, 1, 8'h23); push(8'd6, 1, 1, 8'h26);
        bt_req = 1; bt_level = 8'd0; unwind_ready = 0;
        cyc();
        bt_req = 0;
        cyc();
        #2;
        chk("t5_in_unwind", unwind_valid, 1);
        clear_all = 1;
        cyc();
        clear_all = 0;
        m_clear();
        #2;
        chk("t5_height", height, 0);
        chk("t5_level", current_level, 0);
        chk("t5_idle", push_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_bt_done", bt_done, 0);
            cyc();
            #2;
        end
        cyc();
        check_state("t5");

        for (int i = 0; i < MP; i++) push(8'(i), i[0], (i % 3) == 0, 8'(i + 64));
        #2;
        chk("t6_full_ready", push_ready, 0);
        cyc();
        push(8'd10, 1, 0, 8'h55);
        #2;
        chk("t6_full_height", height, 8);
        cyc();
        check_state("t6");

        do_clear();
        push(8'd5, 1, 1, 8'h31);
        push(8'd5, 0, 0, 8'h32);
        #2;
`ifdef TRAIL_DUP_CHECK_EN
        chk("t7_dup_height", height, 1);
        chk("t7_dup_err", err_dup, 1);
`else
        chk("t7_nodup_height", height, 2);
        chk("t7_nodup_err", err_dup, 0);
`endif
        cyc();
        check_state("t7");

        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)
                push(8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)));
            else if (r < 94)
                backtrack($urandom_range(0, m_lvl + 1), 0, 1, lat);
            else
                do_clear();
            if (it % 25 == 24) check_state("rnd");
        end

        do_clear();
        push(8'd1, 1, 1, 8'h41); push(8'd2, 0, 1, 8'h42); push(8'd3, 1, 1, 8'h43);
        bt_req = 1; bt_level = 8'd0; unwind_ready = 0;
        cyc();
        bt_req = 0;
        cyc();
        reset_n = 0;
        #1;
        chk("t8_rst_height", height, 0);
        chk("t8_rst_unwind", unwind_valid, 0);
        chk("t8_rst_bt_done", bt_done, 0);
        cyc();
        reset_n = 1;
        m_clear();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t8_no_bt_done", bt_done, 0);
            cyc();
        end
        check_state("t8");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
